freq_sel_ctrl: RTL and testbench

Glitch-free frequency-select controller for the 16:1 divider output mux. Requesters ask for a new 4-bit divider tap through a request/acknowledge handshake. The block switches the mux select only at a counter boundary where both the old and new taps are low. After the switch it waits a programmable settle interval, then pulses completion. It runs in the VCO clock domain, alongside the ripple-free divider counter it observes.

---
 rtl/freq_sel_ctrl.sv | 134 +++++++++++++
 tb/tb_freq_sel_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_sel_ctrl.sv
// Glitch-free select controller for the 16:1 divider output mux.
// Accepts a new tap by request/acknowledge, switches only where both taps are low, then settles.
module freq_sel_ctrl #(
  parameter logic [3:0] RESET_SEL     = 4'd6,
  parameter logic [7:0] SETTLE_CYCLES = 8'd4
) (
  input  logic        Fin,
  input  logic        Reset,
  input  logic [14:0] Div_cnt,
  input  logic        Req,
  input  logic [3:0]  Fsel_req,
  output logic        Ack,
  output logic        Busy,
  output logic        Done,
  output logic [3:0]  Fsel
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Low k bits set: the counter bits feeding taps 1..k.
  function automatic logic [14:0] tap_mask(input logic [3:0] k);
    logic [15:0] t;
    t = (16'd1 << k) - 16'd1;
    return t[14:0];
  endfunction

  function automatic logic [3:0] max_sel(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  fsel_r, fsel_s;
  logic [3:0]  target_r, target_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        ack_r, ack_s;
  logic        busy_r;
  logic        done_r;
  logic [3:0]  k_s;
  logic [14:0] mask_s;
  logic        boundary_s;

  // Changeover is safe on the edge where every tap up to the higher select falls to zero.
  always_comb begin
    k_s        = max_sel(fsel_r, target_r);
    mask_s     = tap_mask(k_s);
    boundary_s = ((Div_cnt & mask_s) == mask_s);
  end

  // Next-state, target capture, select update and settle countdown.
  always_comb begin
    state_s  = state_r;
    fsel_s   = fsel_r;
    target_s = target_r;
    cnt_s    = cnt_r;
    ack_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Req) begin
          target_s = Fsel_req;
          ack_s    = 1'b1;
          if (Fsel_req != fsel_r) begin
            state_s = ST_WAIT;
          end else begin
            // Same select: hold one cycle so Done trails Ack by a cycle.
            state_s = ST_SETTLE;
            cnt_s   = 8'd1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (boundary_s) begin
          fsel_s = target_r;
          cnt_s  = SETTLE_CYCLES;
          if (SETTLE_CYCLES == 8'd0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_SETTLE;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SETTLE: begin
        if (cnt_r <= 8'd1) begin
          cnt_s   = 8'd0;
          state_s = ST_DONE;
        end else begin
          cnt_s   = cnt_r - 8'd1;
          state_s = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Fin or posedge Reset) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      fsel_r   <= RESET_SEL;
      target_r <= 4'd0;
      cnt_r    <= 8'd0;
      ack_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      fsel_r   <= fsel_s;
      target_r <= target_s;
      cnt_r    <= cnt_s;
      ack_r    <= ack_s;
      busy_r   <= (state_s != ST_IDLE);
      done_r   <= (state_s == ST_DONE);
    end
  end

  assign Ack  = ack_r;
  assign Busy = busy_r;
  assign Done = done_r;
  assign Fsel = fsel_r;

endmodule

// File: tb/tb_freq_sel_ctrl.sv
// Randomized self-checking bench for freq_sel_ctrl; expected timelines are derived
// per transaction from the handshake and boundary rules with plain arithmetic.
module tb_freq_sel_ctrl;

  logic        Fin = 1'b0;
  logic        Reset;
  logic [14:0] Div_cnt;
  logic        req0, req1;
  logic [3:0]  fsel_req0, fsel_req1;
  logic        ack0, busy0, done0, ack1, busy1, done1;
  logic [3:0]  fsel0, fsel1;

  int compared   = 0;
  int mismatched = 0;
  logic [3:0] exp_fsel [2];

  always #5 Fin = ~Fin;

  freq_sel_ctrl #(.RESET_SEL(4'd6), .SETTLE_CYCLES(8'd4)) u_dut4 (
    .Fin(Fin), .Reset(Reset), .Div_cnt(Div_cnt), .Req(req0), .Fsel_req(fsel_req0),
    .Ack(ack0), .Busy(busy0), .Done(done0), .Fsel(fsel0)
  );

  freq_sel_ctrl #(.RESET_SEL(4'd6), .SETTLE_CYCLES(8'd0)) u_dut0 (
    .Fin(Fin), .Reset(Reset), .Div_cnt(Div_cnt), .Req(req1), .Fsel_req(fsel_req1),
    .Ack(ack1), .Busy(busy1), .Done(done1), .Fsel(fsel1)
  );

  function automatic int settle_of(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic logic [6:0] obs(input int d);
    return (d == 0) ? {ack0, busy0, done0, fsel0} : {ack1, busy1, done1, fsel1};
  endfunction

  function automatic logic tap(input logic [3:0] s, input logic [14:0] c);
    if (s == 4'd0) return 1'b0;
    return c[s - 4'd1];
  endfunction

  // The divider counter advances just after each edge, as a real counter would.
  task automatic tick;
    @(posedge Fin);
    #1;
    Div_cnt = Div_cnt + 15'd1;
  endtask

  task automatic set_req(input int d, input logic r, input logic [3:0] s);
    if (d == 0) begin
      req0 = r; fsel_req0 = s;
    end else begin
      req1 = r; fsel_req1 = s;
    end
  endtask

  // One full transaction: cycle-by-cycle expectation from the transaction timeline.
  task automatic run_request(input int d, input logic [3:0] tgt, input bit noise, input string name);
    logic [3:0] old, prev_f, cur_f, ef;
    logic [6:0] got, expv;
    int k, mask, v0, j, done_n;
    old    = exp_fsel[d];
    k      = (old > tgt) ? int'(old) : int'(tgt);
    mask   = (1 << k) - 1;
    v0     = int'(Div_cnt);
    j      = 1 + ((mask - (v0 + 1)) & mask);
    done_n = (tgt == old) ? 1 : j + settle_of(d);
    prev_f = old;
    set_req(d, 1'b1, tgt);
    for (int n = 0; n <= done_n + 1; n++) begin
      tick;
      ef   = (tgt != old && n >= j) ? tgt : old;
      expv = {(n == 0), (n <= done_n), (n == done_n), ef};
      got  = obs(d);
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL %s dut%0d cycle %0d: ack/busy/done/fsel got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 name, d, n, got[6], got[5], got[4], got[3:0], expv[6], expv[5], expv[4], expv[3:0]);
      end
      cur_f = got[3:0];
      if (cur_f !== prev_f) begin
        compared++;
        if (tap(prev_f, Div_cnt) !== 1'b0 || tap(cur_f, Div_cnt) !== 1'b0) begin
          mismatched++;
          $display("FAIL %s_glitch dut%0d cycle %0d: taps %0d/%0d at Div_cnt=%h got %b/%b expected 0/0",
                   name, d, n, prev_f, cur_f, Div_cnt, tap(prev_f, Div_cnt), tap(cur_f, Div_cnt));
        end
      end
      prev_f = cur_f;
      if (noise && n < done_n) set_req(d, 1'($urandom_range(0, 1)), 4'd9);
      else                     set_req(d, 1'b0, tgt);
    end
    exp_fsel[d] = tgt;
  endtask

  task automatic test_reset;
    logic [6:0] got;
    Reset = 1'b0;
    tick; tick;
    #3 Reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      got = obs(d);
      compared++;
      if (got !== 7'b000_0110) begin
        mismatched++;
        $display("FAIL reset_async dut%0d: got %b expected %b", d, got, 7'b000_0110);
      end
    end
    tick;
    Reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick;
      for (int d = 0; d < 2; d++) begin
        got = obs(d);
        compared++;
        if (got !== 7'b000_0110) begin
          mismatched++;
          $display("FAIL reset_idle dut%0d cycle %0d: got %b expected %b", d, n, got, 7'b000_0110);
        end
      end
    end
    exp_fsel[0] = 4'd6;
    exp_fsel[1] = 4'd6;
  endtask

  task automatic test_same_select;
    run_request(0, 4'd6, 1'b0, "same_select");
  endtask

  task automatic test_switch_6_to_3;
    Div_cnt = 15'h0010;
    run_request(0, 4'd3, 1'b0, "switch_6_to_3");
  endtask

  task automatic test_switch_to_fin;
    run_request(0, 4'd6, 1'b0, "back_to_6");
    run_request(0, 4'd0, 1'b0, "switch_to_fin");
  endtask

  task automatic test_busy_blocking;
    run_request(0, 4'd5, 1'b1, "busy_blocking");
  endtask

  task automatic test_settle_zero;
    run_request(1, 4'd1, 1'b0, "settle0_to_1");
    run_request(1, 4'd2, 1'b0, "settle0_1_to_2");
  endtask

  task automatic test_back_to_back;
    logic [6:0] got, expv;
    int d, gap;
    for (int i = 0; i < 16; i++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) Div_cnt = 15'($urandom);
      run_request(d, 4'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), "random");
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick;
        expv = {3'b000, exp_fsel[d]};
        got  = obs(d);
        compared++;
        if (got !== expv) begin
          mismatched++;
          $display("FAIL idle_gap dut%0d: got %b expected %b", d, got, expv);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [6:0] got, expv;
    logic [3:0] old;
    old     = exp_fsel[0];
    Div_cnt = 15'h0100;
    set_req(0, 1'b1, 4'd15);
    tick;
    set_req(0, 1'b0, 4'd15);
    expv = {3'b110, old};
    got  = obs(0);
    compared++;
    if (got !== expv) begin
      mismatched++;
      $display("FAIL wait15_accept: got %b expected %b", got, expv);
    end
    for (int n = 0; n < 20; n++) begin
      tick;
      expv = {3'b010, old};
      got  = obs(0);
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL wait15_hold cycle %0d: got %b expected %b", n, got, expv);
      end
    end
    #3 Reset = 1'b1;
    #1;
    got = obs(0);
    compared++;
    if (got !== 7'b000_0110) begin
      mismatched++;
      $display("FAIL reset_mid_wait: got %b expected %b", got, 7'b000_0110);
    end
    tick; tick;
    Reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick;
      got = obs(0);
      compared++;
      if (got !== 7'b000_0110) begin
        mismatched++;
        $display("FAIL post_abort cycle %0d: got %b expected %b", n, got, 7'b000_0110);
      end
    end
    exp_fsel[0] = 4'd6;
    exp_fsel[1] = 4'd6;
  endtask

  initial begin
    Reset     = 1'b0;
    Div_cnt   = 15'd0;
    req0      = 1'b0;
    req1      = 1'b0;
    fsel_req0 = 4'd0;
    fsel_req1 = 4'd0;
    test_reset;
    test_same_select;
    test_switch_6_to_3;
    test_switch_to_fin;
    test_busy_blocking;
    test_settle_zero;
    test_back_to_back;
    test_reset_mid_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
